rr_arb2_tuple_bit_bits2: RTL and testbench
==========================================

# rr_arb2_tuple_bit_bits2

Two-input round-robin arbiter with valid/ready handshakes. It sits directly upstream of the Mux2xTupleBit_Bits2 datapath. It chooses one of two Tuple(Bit, Bits(2)) sources each cycle, steers the winner through the mux select, and registers the result into an output stage. The block also emits the registered select S, so downstream logic knows which source produced each beat.

## Interface
Parameters:
- none. The payload is fixed at Tuple(Bit, Bits(2)), packed internally as {_1, _0} (3 bits).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  asynchronous active-low reset; asserting it clears all state immediately.
- I0_valid  input  1  source 0 has a beat.
- I0__0  input  1  source 0 payload, field 0.
- I0__1  input  2  source 0 payload, field 1.
- I0_ready  output  1  source 0 beat accepted this cycle.
- I1_valid, I1__0, I1__1, I1_ready  same as above, for source 1.
- O_valid  output  1  output beat present.
- O__0  output  1  output payload, field 0.
- O__1  output  2  output payload, field 1.
- S  output  1  source index of the current output beat.
- O_ready  input  1  downstream accepts the output beat.

## Operation
- Transfer rule: a transfer occurs on any interface in a cycle where valid and ready are both high.
- Round-robin pointer `last` (1 bit) records the most recently granted source. Reset value: 1, so source 0 wins first.
- Grant, computed combinationally:
  - only one source valid → grant that source;
  - both valid → grant !last;
  - neither valid → no grant.
- Ready signals: I0_ready = grant0 & accept_ok; I1_ready = grant1 & accept_ok. A non-granted source never sees ready.
- `last` updates only on an input transfer. A grant without a transfer (accept_ok low) leaves `last` unchanged, so the same winner is presented again next cycle.
- The winning payload and its grant index travel together. The mux select equals the grant index, and S on the output equals the index of the beat currently on O.
- Output stage: described under Configuration.
- Beats are never dropped, duplicated or reordered. Per-source order is preserved.
- Reset mid-operation discards all buffered beats. No partial state survives.

## Timing
- Latency: 1 cycle. An input accepted at edge N appears on O from edge N onward, i.e. visible in cycle N+1.
- Throughput: 1 beat per cycle when O_ready is held high.
- Reset values: O_valid=0, O__0=0, O__1=2'b00, S=0, I0_ready=0, I1_ready=0, `last`=1, skid empty.
- O__0, O__1 and S come from flops. No combinational path from the I* inputs to O*.
- While O_valid=1 and O_ready=0, O__0, O__1 and S hold stable.
- Simultaneous output pop and input accept in the same cycle: the new beat replaces the popped one with no bubble.

## Configuration
- Macro: RR_ARB2_SKID_EN.
- Defined — two-entry skid buffer (main register plus skid register):
  - accept_ok = !skid_valid, a registered signal, so there is no combinational path from O_ready to I*_ready;
  - when main holds a beat and O_ready=0, an accepted beat goes to skid;
  - when main drains, skid moves to main.
  - Capacity is 2 beats.
- Undefined — single output register:
  - accept_ok = !O_valid | O_ready, which creates a combinational path from O_ready to I*_ready;
  - capacity is 1 beat;
  - full throughput is still achieved while O_ready=1.
- Both builds must pass the same test plan. The only allowed difference is the extra beat of buffering under stall.

## Test plan
- Reset then idle: ASYNCRESETN low mid-cycle → all outputs go to 0 immediately. After release with both valids low, O_valid stays 0 for 10 cycles.
- Single source: I0_valid=1 with payloads (1,2'b10),(0,2'b01),(1,2'b11); O_ready=1 → same three beats appear on O, one per cycle starting 1 cycle later, with S=0 each time.
- Contention: both valid continuously, I0=(0,2'b00), I1=(1,2'b11), O_ready=1 → S alternates 0,1,0,1…, starting with 0, and each source gets exactly 5 of the first 10 beats.
- Backpressure: both valid, O_ready=0 for 4 cycles then 1 → with the macro defined, exactly 2 beats are accepted during the stall; undefined, exactly 1. After release, all beats emerge in grant order and `last` does not advance on stalled grants.
- Stability: with O_valid=1 and O_ready=0, O__0, O__1 and S are unchanged across 5 cycles while the input payloads toggle randomly.
- Reset mid-stream: assert ASYNCRESETN low while the buffer is full → O_valid=0 immediately. After release, the first grant with both sources valid goes to source 0.

Source files
------------

// File: rtl/rr_arb2_tuple_bit_bits2.sv
// Two-source round-robin arbiter feeding a registered Tuple(Bit, Bits(2)) output stage.
// Define RR_ARB2_SKID_EN for a two-entry (main + skid) output buffer; default is a single register.
module rr_arb2_tuple_bit_bits2 (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic       I0_valid,
  input  logic       I0__0,
  input  logic [1:0] I0__1,
  output logic       I0_ready,
  input  logic       I1_valid,
  input  logic       I1__0,
  input  logic [1:0] I1__1,
  output logic       I1_ready,
  output logic       O_valid,
  output logic       O__0,
  output logic [1:0] O__1,
  output logic       S,
  input  logic       O_ready
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic [1:0] f1;
    logic       f0;
  } pay_t;

  typedef struct packed {
    logic idx;
    pay_t pay;
  } beat_t;

  logic [NUM_SRC-1:0] src_valid, grant;
  pay_t [NUM_SRC-1:0] src_pay;
  logic               last, accept_ok, in_xfer;
  beat_t              win, main_q;
  logic               main_v;

  assign src_valid  = {I1_valid, I0_valid};
  assign src_pay[0] = {I0__1, I0__0};
  assign src_pay[1] = {I1__1, I1__0};

  // On contention the source that did not win the last transfer goes first.
  assign grant[0] = src_valid[0] & (~src_valid[1] | last);
  assign grant[1] = src_valid[1] & (~src_valid[0] | ~last);

  assign win.idx  = grant[1];
  assign win.pay  = src_pay[grant[1]];
  assign in_xfer  = (|grant) & accept_ok;
  assign I0_ready = grant[0] & accept_ok;
  assign I1_ready = grant[1] & accept_ok;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) last <= 1'b1;
    else if (in_xfer) last <= win.idx;
  end

`ifdef RR_ARB2_SKID_EN
  logic  skid_v;
  beat_t skid_q;
  logic  pop;

  // Registered accept: O_ready never reaches the input ready paths.
  assign accept_ok = ASYNCRESETN & ~skid_v;
  assign pop       = main_v & O_ready;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      main_v <= 1'b0;
      main_q <= '0;
      skid_v <= 1'b0;
      skid_q <= '0;
    end else if (skid_v) begin
      if (pop) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_v || pop) begin
        main_q <= win;
        main_v <= 1'b1;
      end else begin
        skid_q <= win;
        skid_v <= 1'b1;
      end
    end else if (pop) begin
      main_v <= 1'b0;
    end
  end
`else
  // Accept when the register is empty or being drained this cycle.
  assign accept_ok = ASYNCRESETN & (~main_v | O_ready);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      main_v <= 1'b0;
      main_q <= '0;
    end else if (in_xfer) begin
      main_q <= win;
      main_v <= 1'b1;
    end else if (O_ready) begin
      main_v <= 1'b0;
    end
  end
`endif

  assign O_valid = main_v;
  assign O__0    = main_q.pay.f0;
  assign O__1    = main_q.pay.f1;
  assign S       = main_q.idx;
endmodule

// File: tb/tb_rr_arb2_tuple_bit_bits2.sv
// Directed bench for rr_arb2_tuple_bit_bits2 with a beat scoreboard and an occupancy/pointer model.
module tb_rr_arb2_tuple_bit_bits2;
  logic       CLK = 1'b0;
  logic       ASYNCRESETN = 1'b1;
  logic       I0_valid = 1'b0, I0__0 = 1'b0, I1_valid = 1'b0, I1__0 = 1'b0;
  logic [1:0] I0__1 = 2'b00, I1__1 = 2'b00;
  logic       I0_ready, I1_ready, O_valid, O__0, S;
  logic [1:0] O__1;
  logic       O_ready = 1'b0;

`ifdef RR_ARB2_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  rr_arb2_tuple_bit_bits2 dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I0_valid(I0_valid), .I0__0(I0__0), .I0__1(I0__1), .I0_ready(I0_ready),
    .I1_valid(I1_valid), .I1__0(I1__0), .I1__1(I1__1), .I1_ready(I1_ready),
    .O_valid(O_valid), .O__0(O__0), .O__1(O__1), .S(S), .O_ready(O_ready)
  );

  always #5 CLK = ~CLK;

  int         passed = 0, total = 0;
  logic [3:0] q[$];
  logic       m_last = 1'b1;
  int         xfers = 0, pops0 = 0, pops1 = 0;
  logic       first_s = 1'b1;
  logic [3:0] snap;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check ready/output against the model, then advance the model past the edge.
  task automatic cycle();
    logic       g0, g1, acc, push, pop;
    logic [3:0] nb;
    #1;
    g0 = I0_valid & (~I1_valid | m_last);
    g1 = I1_valid & (~I0_valid | ~m_last);
`ifdef RR_ARB2_SKID_EN
    acc = (q.size() < 2);
`else
    acc = (q.size() == 0) || O_ready;
`endif
    chk("i0_ready", {3'b0, I0_ready}, {3'b0, g0 & acc});
    chk("i1_ready", {3'b0, I1_ready}, {3'b0, g1 & acc});
    chk("o_valid", {3'b0, O_valid}, {3'b0, q.size() != 0});
    if (q.size() != 0) chk("o_beat", {S, O__1, O__0}, q[0]);
    push = (g0 | g1) & acc;
    nb   = g1 ? {1'b1, I1__1, I1__0} : {1'b0, I0__1, I0__0};
    pop  = O_ready && (q.size() != 0);
    if ((I0_valid & I0_ready) | (I1_valid & I1_ready)) xfers++;
    if (pop && (pops0 + pops1 < 10)) begin
      if (pops0 + pops1 == 0) first_s = q[0][3];
      if (q[0][3]) pops1++; else pops0++;
    end
    @(posedge CLK); #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(nb);
      m_last = g1;
    end
  endtask

  task automatic do_reset();
    #3 ASYNCRESETN = 1'b0;
    #1;
    chk("rst_o_valid", {3'b0, O_valid}, 4'h0);
    chk("rst_o_beat", {S, O__1, O__0}, 4'h0);
    chk("rst_ready", {2'b0, I1_ready, I0_ready}, 4'h0);
    q.delete();
    m_last = 1'b1;
    @(posedge CLK); #3;
    ASYNCRESETN = 1'b1;
  endtask

  initial begin
    // Reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) cycle();

    // Single source
    O_ready = 1'b1;
    I0_valid = 1'b1; {I0__0, I0__1} = {1'b1, 2'b10}; cycle();
    {I0__0, I0__1} = {1'b0, 2'b01}; cycle();
    {I0__0, I0__1} = {1'b1, 2'b11}; cycle();
    I0_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Contention
    do_reset();
    pops0 = 0; pops1 = 0;
    I0_valid = 1'b1; {I0__0, I0__1} = {1'b0, 2'b00};
    I1_valid = 1'b1; {I1__0, I1__1} = {1'b1, 2'b11};
    for (int i = 0; i < 11; i++) cycle();
    chk("cont_first_s", {3'b0, first_s}, 4'h0);
    chk("cont_src0_beats", 4'(pops0), 4'd5);
    chk("cont_src1_beats", 4'(pops1), 4'd5);

    // Backpressure
    I0_valid = 1'b0; I1_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    O_ready = 1'b0; xfers = 0;
    I0_valid = 1'b1; {I0__0, I0__1} = {1'b1, 2'b01};
    I1_valid = 1'b1; {I1__0, I1__1} = {1'b0, 2'b10};
    for (int i = 0; i < 4; i++) cycle();
    chk("stall_accepts", 4'(xfers), 4'(CAP));
    O_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    I0_valid = 1'b0; I1_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("bp_drained", {3'b0, O_valid}, 4'h0);

    // Stability under stall with toggling inputs
    O_ready = 1'b0;
    I0_valid = 1'b1; I1_valid = 1'b1;
    cycle();
    snap = {S, O__1, O__0};
    for (int i = 0; i < 5; i++) begin
      I0__0 = 1'($urandom); I0__1 = 2'($urandom);
      I1__0 = 1'($urandom); I1__1 = 2'($urandom);
      cycle();
      chk("stall_stable", {S, O__1, O__0}, snap);
    end

    // Reset mid-stream with the buffer full
    do_reset();
    O_ready = 1'b1;
    #1 chk("post_rst_grant0", {2'b0, I1_ready, I0_ready}, 4'h1);
    cycle();
    I0_valid = 1'b0; I1_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
